alu_pipe_fifo: RTL and testbench
================================

Name: alu_pipe_fifo

Overview:
- Parametrised successor to the 8-bit HAVEN ALU DUT: generic DATA_WIDTH, iterative multi-cycle multiplier, output result FIFO with downstream backpressure.
- Sits between the ALU driver (ACT/ALU_RDY handshake) and the monitor/scoreboard.
- Gives the GA environment a DUT whose delays and backpressure exercise real stall behaviour.

Parameters:
- DATA_WIDTH, 8, operand width; legal range 4..32.
- FIFO_DEPTH, 4, result FIFO entries; power of two, minimum 2.

Ports:
- CLK  in  1  single clock; all logic on the rising edge.
- RST  in  1  synchronous, active-high reset.
- ACT  in  1  operation request valid.
- ALU_RDY  out  1  block can accept an operation this cycle.
- OP  in  4  opcode.
- MOVI  in  2  operand-B source select.
- REG_A  in  DATA_WIDTH  operand A.
- REG_B  in  DATA_WIDTH  operand B, register source.
- MEM  in  DATA_WIDTH  operand B, memory source.
- IMM  in  DATA_WIDTH  operand B, immediate source.
- EX_ALU  out  2*DATA_WIDTH  result at FIFO head.
- EX_ALU_VLD  out  1  FIFO non-empty; EX_ALU valid.
- OUT_RDY  in  1  consumer accepts EX_ALU this cycle.

Behaviour:
- Clocking and reset: one clock, CLK. RST is synchronous and active-high.
- RST sampled high: FSM goes to IDLE, the FIFO empties, and the stage register and multiplier are cleared.
- During and immediately after reset: ALU_RDY=0, EX_ALU_VLD=0, EX_ALU=0.
- Reset mid-multiply aborts the operation; no result is produced.
- Accept: an operation is accepted when ACT && ALU_RDY at a rising edge. ACT while ALU_RDY=0 is ignored; the driver holds it.
- Operand B by MOVI:
  - 00 → REG_B
  - 01 → MEM
  - 10 → IMM
  - 11 → zero
- OP encoding; results are zero-extended to 2*DATA_WIDTH unless noted:
  - 0 ADD (carry in bit DATA_WIDTH)
  - 1 SUB (borrow as 1 in bit DATA_WIDTH)
  - 2 MULT (full 2*DATA_WIDTH product)
  - 3 SHL by 1
  - 4 SHR by 1
  - 5 ROL by 1
  - 6 ROR by 1
  - 7 NOT A
  - 8 AND, 9 OR, 10 XOR, 11 NAND, 12 NOR, 13 XNOR
  - 14 INC A (carry in bit DATA_WIDTH)
  - 15 DEC A (borrow as 1 in bit DATA_WIDTH)
- Single-cycle path, all ops except MULT:
  - Result is computed and registered in the stage register on the accept edge, then pushed into the FIFO on the next edge.
  - ACT in cycle k gives EX_ALU_VLD=1 in cycle k+2.
  - Back-to-back accepts are allowed.
- Multiply path, states IDLE and MUL_BUSY:
  - IDLE→MUL_BUSY on MULT accept; operands latched, counter loaded with DATA_WIDTH.
  - In MUL_BUSY: one shift-add step per cycle, ALU_RDY=0.
  - When the counter reaches 0, the product is pushed and the FSM returns to IDLE.
  - Result is visible in cycle k+DATA_WIDTH+2.
  - ALU_RDY returns high in the cycle after the push, space permitting.
- Ordering: results leave in acceptance order. Any single-cycle result already in the stage register is pushed before the multiply completes.
- FIFO:
  - First-word-fall-through: EX_ALU is combinational from the head.
  - Pop when EX_ALU_VLD && OUT_RDY; EX_ALU holds while OUT_RDY=0.
  - Simultaneous push and pop leaves the count unchanged, including at full.
  - Pop while empty is ignored.
  - Pointers wrap modulo FIFO_DEPTH.
- ALU_RDY = !RST_state && FSM==IDLE && (count + inflight) < FIFO_DEPTH.
  - inflight counts a valid stage register or an active multiply.
  - The FIFO therefore never overflows; no result is ever dropped.
- OUT_RDY held low indefinitely: the FIFO fills, then ALU_RDY stays 0 until a pop occurs.

Optional Feature:
- ALU_FLAGS_EN defined:
  - Adds output EX_FLAGS[3:0] = {Z, C, N, V}, stored per FIFO entry alongside the result.
  - Z = result==0; C = bit DATA_WIDTH; N = MSB of the DATA_WIDTH-bit result; V = signed overflow for ADD/SUB/INC/DEC, otherwise 0.
  - For MULT: C = upper half non-zero.
  - Reset value 0.
- ALU_FLAGS_EN undefined: the port and the flag storage are absent; all other behaviour is identical.

Test Plan:
- Reset: DATA_WIDTH=8, RST high 10 cycles with ACT=1 → ALU_RDY=0 and EX_ALU_VLD=0 throughout; ALU_RDY=1 one cycle after RST drops.
- Carry-out: ADD, REG_A=0xFF, MOVI=00, REG_B=0x01, OUT_RDY=1 → EX_ALU=0x0100, VLD two cycles after ACT. With ALU_FLAGS_EN: FLAGS C=1, Z=0.
- Multiply: MULT, 0xFF×IMM=0xFF, MOVI=10 → ALU_RDY low 8 cycles; EX_ALU=0xFE01 in cycle k+10. Then a back-to-back SUB 0x00−MEM 0x01 → 0x01FF, emitted after the product.
- Backpressure: OUT_RDY=0, FIFO_DEPTH=4, stream 6 XORs → ALU_RDY drops after the 4th accept. OUT_RDY=1 → results pop in order; ALU_RDY reasserts.
- Reset mid-multiply: RST asserted 3 cycles into a MULT → no result emitted; next ADD 0x02+0x03 → 0x0005.
- Wrap and simultaneous push/pop: 20 INC ops with OUT_RDY toggling every cycle → every result matches the model, no drops; count never exceeds 4.

Source files
------------

// File: rtl/alu_pipe_fifo.sv
// alu_pipe_fifo: parametrised ALU with an iterative shift-add multiplier and a first-word-fall-through result FIFO.
// Optional macro ALU_FLAGS_EN adds per-result {Z,C,N,V} flags on EX_FLAGS.
module alu_pipe_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic                      ACT,
    output logic                      ALU_RDY,
    input  logic [3:0]                OP,
    input  logic [1:0]                MOVI,
    input  logic [DATA_WIDTH-1:0]     REG_A,
    input  logic [DATA_WIDTH-1:0]     REG_B,
    input  logic [DATA_WIDTH-1:0]     MEM,
    input  logic [DATA_WIDTH-1:0]     IMM,
    output logic [2*DATA_WIDTH-1:0]   EX_ALU,
    output logic                      EX_ALU_VLD,
    input  logic                      OUT_RDY
`ifdef ALU_FLAGS_EN
    ,
    output logic [3:0]                EX_FLAGS
`endif
);

    localparam int W  = DATA_WIDTH;
    localparam int RW = 2 * DATA_WIDTH;
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int NW = $clog2(DATA_WIDTH + 1);
    localparam logic [CW:0]   DEPTH_C     = (CW+1)'(FIFO_DEPTH);
    localparam logic [NW-1:0] MUL_STEPS_C = NW'(DATA_WIDTH);
    localparam logic [NW-1:0] LAST_STEP_C = NW'(1);

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_MULT = 4'd2;
    localparam logic [3:0] OP_SHL  = 4'd3;
    localparam logic [3:0] OP_SHR  = 4'd4;
    localparam logic [3:0] OP_ROL  = 4'd5;
    localparam logic [3:0] OP_ROR  = 4'd6;
    localparam logic [3:0] OP_NOT  = 4'd7;
    localparam logic [3:0] OP_AND  = 4'd8;
    localparam logic [3:0] OP_OR   = 4'd9;
    localparam logic [3:0] OP_XOR  = 4'd10;
    localparam logic [3:0] OP_NAND = 4'd11;
    localparam logic [3:0] OP_NOR  = 4'd12;
    localparam logic [3:0] OP_XNOR = 4'd13;
    localparam logic [3:0] OP_INC  = 4'd14;
    localparam logic [3:0] OP_DEC  = 4'd15;

    typedef enum logic [0:0] {
        S_IDLE     = 1'b0,
        S_MUL_BUSY = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic               rst_q;
    logic [W-1:0]       opb_s;
    logic [W:0]         wide_s;
    logic [RW-1:0]      alu_res_s;
    logic               accept_s;
    logic               accept_mul_s;
    logic               mul_done_s;
    logic               inflight_s;
    logic [CW:0]        occ_s;

    logic [RW-1:0]      mcand_q;
    logic [W-1:0]       mplier_q;
    logic [RW-1:0]      acc_q;
    logic [RW-1:0]      acc_step_s;
    logic [NW-1:0]      cnt_q;

    logic               stage_vld_q;
    logic [RW-1:0]      stage_res_q;

    logic [RW-1:0]      fifo_mem_q [FIFO_DEPTH];
    logic [AW-1:0]      wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]      count_q, count_d;
    logic               push_s, pop_s;

`ifdef ALU_FLAGS_EN
    logic [3:0]         alu_flags_s;
    logic [3:0]         mul_flags_s;
    logic               ovf_s;
    logic [3:0]         stage_flags_q;
    logic [3:0]         flag_mem_q [FIFO_DEPTH];
`endif

    // Operand B source select.
    always_comb begin
        case (MOVI)
            2'b00:   opb_s = REG_B;
            2'b01:   opb_s = MEM;
            2'b10:   opb_s = IMM;
            default: opb_s = '0;
        endcase
    end

    // Single-cycle datapath; bit W carries the carry or borrow where the op defines one.
    always_comb begin
        case (OP)
            OP_ADD:  wide_s = {1'b0, REG_A} + {1'b0, opb_s};
            OP_SUB:  wide_s = {1'b0, REG_A} - {1'b0, opb_s};
            OP_SHL:  wide_s = {1'b0, REG_A[W-2:0], 1'b0};
            OP_SHR:  wide_s = {2'b00, REG_A[W-1:1]};
            OP_ROL:  wide_s = {1'b0, REG_A[W-2:0], REG_A[W-1]};
            OP_ROR:  wide_s = {1'b0, REG_A[0], REG_A[W-1:1]};
            OP_NOT:  wide_s = {1'b0, ~REG_A};
            OP_AND:  wide_s = {1'b0, REG_A & opb_s};
            OP_OR:   wide_s = {1'b0, REG_A | opb_s};
            OP_XOR:  wide_s = {1'b0, REG_A ^ opb_s};
            OP_NAND: wide_s = {1'b0, ~(REG_A & opb_s)};
            OP_NOR:  wide_s = {1'b0, ~(REG_A | opb_s)};
            OP_XNOR: wide_s = {1'b0, ~(REG_A ^ opb_s)};
            OP_INC:  wide_s = {1'b0, REG_A} + {{W{1'b0}}, 1'b1};
            OP_DEC:  wide_s = {1'b0, REG_A} - {{W{1'b0}}, 1'b1};
            default: wide_s = '0;
        endcase
        alu_res_s = {{(W-1){1'b0}}, wide_s};
    end

`ifdef ALU_FLAGS_EN
    // Flag generation for single-cycle results and for the finished product.
    always_comb begin
        case (OP)
            OP_ADD:  ovf_s = (REG_A[W-1] == opb_s[W-1]) && (wide_s[W-1] != REG_A[W-1]);
            OP_SUB:  ovf_s = (REG_A[W-1] != opb_s[W-1]) && (wide_s[W-1] != REG_A[W-1]);
            OP_INC:  ovf_s = !REG_A[W-1] && wide_s[W-1];
            OP_DEC:  ovf_s = REG_A[W-1] && !wide_s[W-1];
            default: ovf_s = 1'b0;
        endcase
        alu_flags_s = {(wide_s == '0), wide_s[W], wide_s[W-1], ovf_s};
        mul_flags_s = {(acc_step_s == '0), (|acc_step_s[RW-1:W]), acc_step_s[W-1], 1'b0};
    end
`endif

    // Accept and readiness; an active multiply or a full stage register reserves a FIFO slot.
    always_comb begin
        inflight_s   = stage_vld_q || (state_q == S_MUL_BUSY);
        occ_s        = {1'b0, count_q} + {{CW{1'b0}}, inflight_s};
        ALU_RDY      = !RST && !rst_q && (state_q == S_IDLE) && (occ_s < DEPTH_C);
        accept_s     = ACT && ALU_RDY;
        accept_mul_s = accept_s && (OP == OP_MULT);
        acc_step_s   = acc_q + (mplier_q[0] ? mcand_q : {RW{1'b0}});
    end

    // Multiplier FSM next state: the last shift-add step hands the product to the stage register.
    always_comb begin
        state_d    = state_q;
        mul_done_s = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (accept_mul_s) begin
                    state_d = S_MUL_BUSY;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_MUL_BUSY: begin
                if (cnt_q == LAST_STEP_C) begin
                    state_d    = S_IDLE;
                    mul_done_s = 1'b1;
                end else begin
                    state_d = S_MUL_BUSY;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State register and reset trace used to hold ALU_RDY low for one cycle after reset.
    always_ff @(posedge CLK) begin
        rst_q <= RST;
        if (RST) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Shift-add multiplier datapath.
    always_ff @(posedge CLK) begin
        if (RST) begin
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
        end else if (accept_mul_s) begin
            mcand_q  <= {{W{1'b0}}, REG_A};
            mplier_q <= opb_s;
            acc_q    <= '0;
            cnt_q    <= MUL_STEPS_C;
        end else if (state_q == S_MUL_BUSY) begin
            mcand_q  <= {mcand_q[RW-2:0], 1'b0};
            mplier_q <= {1'b0, mplier_q[W-1:1]};
            acc_q    <= acc_step_s;
            cnt_q    <= cnt_q - LAST_STEP_C;
        end
    end

    // Stage register: one result per cycle, always drained into the FIFO on the next edge.
    always_ff @(posedge CLK) begin
        if (RST) begin
            stage_vld_q   <= 1'b0;
            stage_res_q   <= '0;
`ifdef ALU_FLAGS_EN
            stage_flags_q <= 4'b0000;
`endif
        end else if (accept_s && !accept_mul_s) begin
            stage_vld_q   <= 1'b1;
            stage_res_q   <= alu_res_s;
`ifdef ALU_FLAGS_EN
            stage_flags_q <= alu_flags_s;
`endif
        end else if (mul_done_s) begin
            stage_vld_q   <= 1'b1;
            stage_res_q   <= acc_step_s;
`ifdef ALU_FLAGS_EN
            stage_flags_q <= mul_flags_s;
`endif
        end else begin
            stage_vld_q   <= 1'b0;
        end
    end

    // FIFO occupancy; readiness guarantees a free slot for every push.
    always_comb begin
        push_s = stage_vld_q;
        pop_s  = EX_ALU_VLD && OUT_RDY;
        case ({push_s, pop_s})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // FIFO pointers and count.
    always_ff @(posedge CLK) begin
        if (RST) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_s) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (pop_s) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            count_q <= count_d;
        end
    end

    // FIFO storage; contents are never visible while the FIFO is empty.
    always_ff @(posedge CLK) begin
        if (push_s && !RST) begin
            fifo_mem_q[wr_ptr_q] <= stage_res_q;
`ifdef ALU_FLAGS_EN
            flag_mem_q[wr_ptr_q] <= stage_flags_q;
`endif
        end
    end

    // First-word-fall-through head, forced to zero when empty or in reset.
    always_comb begin
        EX_ALU_VLD = !RST && (count_q != '0);
        if (EX_ALU_VLD) begin
            EX_ALU = fifo_mem_q[rd_ptr_q];
        end else begin
            EX_ALU = '0;
        end
`ifdef ALU_FLAGS_EN
        if (EX_ALU_VLD) begin
            EX_FLAGS = flag_mem_q[rd_ptr_q];
        end else begin
            EX_FLAGS = 4'b0000;
        end
`endif
    end

endmodule

// File: tb/tb_alu_pipe_fifo.sv
// Directed self-checking bench for alu_pipe_fifo (DATA_WIDTH=8, FIFO_DEPTH=4).
module tb_alu_pipe_fifo;

    logic        CLK;
    logic        RST;
    logic        ACT;
    logic        ALU_RDY;
    logic [3:0]  OP;
    logic [1:0]  MOVI;
    logic [7:0]  REG_A, REG_B, MEM, IMM;
    logic [15:0] EX_ALU;
    logic        EX_ALU_VLD;
    logic        OUT_RDY;
`ifdef ALU_FLAGS_EN
    logic [3:0]  EX_FLAGS;
`endif

    int          n_tests = 0;
    int          n_fail  = 0;
    int          n_acc   = 0;
    int          n_pop   = 0;
    int          max_out = 0;
    logic        toggle_rdy = 1'b0;
    logic [15:0] got[$];
    logic [15:0] exp_q[$];

    alu_pipe_fifo #(.DATA_WIDTH(8), .FIFO_DEPTH(4)) dut (
        .CLK(CLK), .RST(RST), .ACT(ACT), .ALU_RDY(ALU_RDY),
        .OP(OP), .MOVI(MOVI), .REG_A(REG_A), .REG_B(REG_B),
        .MEM(MEM), .IMM(IMM), .EX_ALU(EX_ALU), .EX_ALU_VLD(EX_ALU_VLD),
        .OUT_RDY(OUT_RDY)
`ifdef ALU_FLAGS_EN
        , .EX_FLAGS(EX_FLAGS)
`endif
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs are stable here, so log accepts and pops before the edge.
    task automatic tick();
        if (!RST && ACT && ALU_RDY) n_acc++;
        if (!RST && EX_ALU_VLD && OUT_RDY) begin
            got.push_back(EX_ALU);
            n_pop++;
        end
        @(posedge CLK);
        #1;
        if (n_acc - n_pop > max_out) max_out = n_acc - n_pop;
        if (toggle_rdy) OUT_RDY = !OUT_RDY;
    endtask

    // Present an op and hold ACT until it is accepted; returns in the cycle after the accept edge.
    task automatic issue(input logic [3:0] op, input logic [1:0] movi,
                         input logic [7:0] a, input logic [7:0] b);
        logic done;
        done  = 1'b0;
        OP    = op;
        MOVI  = movi;
        REG_A = a;
        REG_B = 8'hA5;
        MEM   = 8'h5A;
        IMM   = 8'h3C;
        case (movi)
            2'b00:   REG_B = b;
            2'b01:   MEM   = b;
            2'b10:   IMM   = b;
            default: REG_B = 8'hA5;
        endcase
        ACT = 1'b1;
        for (int t = 0; t < 200 && !done; t++) begin
            if (ALU_RDY) done = 1'b1;
            tick();
        end
        ACT = 1'b0;
        if (!done) check("issue_timeout", 64'd0, 64'd1);
    endtask

    task automatic drain(input int n);
        for (int t = 0; t < 300 && got.size() < n; t++) tick();
        if (got.size() < n) check("drain_timeout", 64'(got.size()), 64'(n));
    endtask

    logic [7:0] bp_a [6] = '{8'h0F, 8'hF0, 8'hAA, 8'h55, 8'h12, 8'hC3};
    logic [7:0] bp_b [6] = '{8'hFF, 8'h0F, 8'h0F, 8'h55, 8'h34, 8'h01};
    logic [15:0] bp_e [6] = '{16'h00F0, 16'h00FF, 16'h00A5, 16'h0000, 16'h0026, 16'h00C2};

    initial begin
        logic       vld_seen;
        logic [7:0] a;
        RST = 1'b1; ACT = 1'b1; OP = 4'd0; MOVI = 2'b00;
        REG_A = 8'h01; REG_B = 8'h01; MEM = 8'h00; IMM = 8'h00; OUT_RDY = 1'b1;

        // Reset held with ACT high.
        for (int i = 0; i < 10; i++) begin
            tick();
            check("rst_rdy", ALU_RDY, 1'b0);
            check("rst_vld", EX_ALU_VLD, 1'b0);
            check("rst_data", EX_ALU, 16'h0000);
        end
        RST = 1'b0; ACT = 1'b0;
        check("rst_rdy_after_drop", ALU_RDY, 1'b0);
        tick();
        check("rdy_one_cycle_after_rst", ALU_RDY, 1'b1);

        // ADD with carry out.
        issue(4'd0, 2'b00, 8'hFF, 8'h01);
        check("add_vld_k1", EX_ALU_VLD, 1'b0);
        tick();
        check("add_vld_k2", EX_ALU_VLD, 1'b1);
        check("add_carry", EX_ALU, 16'h0100);
`ifdef ALU_FLAGS_EN
        check("add_flags", EX_FLAGS, 4'b0100);
`endif
        tick();
        check("add_popped", EX_ALU_VLD, 1'b0);

        // MULT then back-to-back SUB.
        issue(4'd2, 2'b10, 8'hFF, 8'hFF);
        for (int i = 0; i < 8; i++) begin
            check("mul_rdy_low", ALU_RDY, 1'b0);
            check("mul_vld_low", EX_ALU_VLD, 1'b0);
            tick();
        end
        check("mul_rdy_back", ALU_RDY, 1'b1);
        check("mul_vld_k9", EX_ALU_VLD, 1'b0);
        issue(4'd1, 2'b01, 8'h00, 8'h01);
        check("mul_vld_k10", EX_ALU_VLD, 1'b1);
        check("mul_product", EX_ALU, 16'hFE01);
`ifdef ALU_FLAGS_EN
        check("mul_flags", EX_FLAGS, 4'b0100);
`endif
        tick();
        check("sub_vld", EX_ALU_VLD, 1'b1);
        check("sub_borrow", EX_ALU, 16'h01FF);
`ifdef ALU_FLAGS_EN
        check("sub_flags", EX_FLAGS, 4'b0110);
`endif
        tick();
        check("mulsub_drained", EX_ALU_VLD, 1'b0);

        // Backpressure: fill the FIFO, then release.
        got.delete();
        OUT_RDY = 1'b0;
        for (int i = 0; i < 4; i++) issue(4'd10, 2'(i % 3), bp_a[i], bp_b[i]);
        check("bp_rdy_drop", ALU_RDY, 1'b0);
        for (int i = 0; i < 5; i++) tick();
        check("bp_rdy_held", ALU_RDY, 1'b0);
        check("bp_head_hold", EX_ALU, 16'h00F0);
        check("bp_vld_hold", EX_ALU_VLD, 1'b1);
        OUT_RDY = 1'b1;
        for (int i = 4; i < 6; i++) issue(4'd10, 2'(i % 3), bp_a[i], bp_b[i]);
        drain(6);
        check("bp_count", 64'(got.size()), 64'd6);
        for (int i = 0; i < 6 && i < got.size(); i++) check("bp_order", got[i], bp_e[i]);

        // Reset three cycles into a multiply.
        for (int i = 0; i < 3; i++) tick();
        got.delete();
        issue(4'd2, 2'b00, 8'h12, 8'h34);
        tick();
        tick();
        RST = 1'b1;
        tick();
        tick();
        RST = 1'b0;
        vld_seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            vld_seen = vld_seen | EX_ALU_VLD;
            tick();
        end
        check("abort_no_result", vld_seen, 1'b0);
        issue(4'd0, 2'b00, 8'h02, 8'h03);
        drain(1);
        for (int i = 0; i < 3; i++) tick();
        check("abort_count", 64'(got.size()), 64'd1);
        if (got.size() > 0) check("post_abort_add", got[0], 16'h0005);

        // Wrap-around with OUT_RDY toggling every cycle.
        got.delete();
        exp_q.delete();
        n_acc = 0; n_pop = 0; max_out = 0;
        OUT_RDY = 1'b1;
        toggle_rdy = 1'b1;
        for (int i = 0; i < 20; i++) begin
            a = (i == 7) ? 8'hFF : 8'(i * 37 + 5);
            exp_q.push_back({8'h00, a} + 16'd1);
            issue(4'd14, 2'b11, a, 8'h00);
        end
        drain(20);
        toggle_rdy = 1'b0;
        OUT_RDY = 1'b1;
        check("wrap_count", 64'(got.size()), 64'd20);
        for (int i = 0; i < 20 && i < got.size(); i++) check("wrap_inc", got[i], exp_q[i]);
        check("max_outstanding_le_depth", (max_out <= 4), 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
